fifo_ram2_ctrl: RTL and testbench

Synchronous FIFO controller that owns the write/read pointers, flow control and status for the `ram2_port` simple-dual-port RAM. It sits directly in front of `ram2_port`, generating `wraddress`/`wren`/`data` and `rdaddress`, and presents a push/pop FIFO interface to the producer and consumer. Both RAM ports run on the single system clock.

---
 rtl/fifo_ram2_ctrl_pkg.sv | 18 +
 rtl/fifo_ram2_ctrl_ram2_port.sv | 34 +++
 rtl/fifo_ram2_ctrl.sv | 98 +++++++++
 tb/tb_fifo_ram2_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ram2_ctrl_pkg.sv
// Shared constants for the ram2_port FIFO controller and other ram2_port users.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
// Contents: default data/address widths, RAM read latency, pointer-width helper.
package fifo_ram2_ctrl_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_ADDR_W = 8;

  // Cycles from rdaddress being registered to q being valid.
  localparam int RAM_RD_LAT = 1;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_ram2_ctrl_ram2_port.sv
// Simple dual-port RAM: one write port and one registered read port.
// Latency: rdaddress is sampled on an edge and q is valid after that edge.
// Backpressure: none; every write and read is taken.
// Ports: wrclock/wren/wraddress/data write one word; rdclock/rdaddress/q read.
module ram2_port
  import fifo_ram2_ctrl_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              wrclock,
  input  logic              wren,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic [DATA_W-1:0] data,
  input  logic              rdclock,
  input  logic [ADDR_W-1:0] rdaddress,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge wrclock) begin
    if (wren) begin
      mem[wraddress] <= data;
    end
  end

  // Read address is re-sampled every edge; the controller holds it steady
  // between pops so q stays stable too.
  always_ff @(posedge rdclock) begin
    q <= mem[rdaddress];
  end

endmodule

// File: rtl/fifo_ram2_ctrl.sv
// Synchronous FIFO controller driving a ram2_port: pointers, flags, occupancy.
// Latency: pop accepted on edge N gives rd_valid/rd_data after edge N; push to earliest data is 2 cycles.
// Backpressure: full rejects pushes (sets ovf), empty rejects pops (sets udf); rejected requests change nothing.
// Ports: sclk/srst (sync, active-high); wr_en/wr_data/full push side;
//        rd_en/rd_data/rd_valid/empty pop side; count occupancy; ovf/udf sticky error flags.
module fifo_ram2_ctrl
  import fifo_ram2_ctrl_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              sclk,
  input  logic              srst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              udf
);

  localparam int PTR_W = ptr_width(ADDR_W);

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  wren;
  logic [ADDR_W-1:0]     wraddress;
  logic [DATA_W-1:0]     data;
  logic [ADDR_W-1:0]     rdaddress;
  logic [ADDR_W-1:0]     rdaddress_last;
  logic [RAM_RD_LAT-1:0] vld_pipe;

  // Flags come straight from the registered pointers.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count = wr_ptr - rd_ptr;

  // Reset wins over any request in the same cycle, including the RAM write.
  assign push = wr_en && !full && !srst;
  assign pop  = rd_en && !empty && !srst;

  assign wren      = push;
  assign wraddress = wr_ptr[ADDR_W-1:0];
  assign data      = wr_data;

  // Hold the last popped address when idle so q does not move under the consumer.
  assign rdaddress = pop ? rd_ptr[ADDR_W-1:0] : rdaddress_last;

  assign rd_valid = vld_pipe[RAM_RD_LAT-1];

  always_ff @(posedge sclk) begin
    if (srst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rdaddress_last <= '0;
      vld_pipe       <= '0;
      ovf            <= 1'b0;
      udf            <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr         <= rd_ptr + PTR_W'(1);
        rdaddress_last <= rd_ptr[ADDR_W-1:0];
      end
      // rd_valid tracks the RAM read latency so it lines up with q.
      vld_pipe <= (vld_pipe << 1) | RAM_RD_LAT'(pop);
      if (wr_en && full) begin
        ovf <= 1'b1;
      end
      if (rd_en && empty) begin
        udf <= 1'b1;
      end
    end
  end

  ram2_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .wrclock  (sclk),
    .wren     (wren),
    .wraddress(wraddress),
    .data     (data),
    .rdclock  (sclk),
    .rdaddress(rdaddress),
    .q        (rd_data)
  );

endmodule

// File: tb/tb_fifo_ram2_ctrl.sv
// Bench for fifo_ram2_ctrl: directed table, corner sequences, randomized traffic.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: exercised via full/empty corners and random bursts.
module tb_fifo_ram2_ctrl;

  logic       sclk;
  logic       srst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic [8:0] count;
  logic       ovf;
  logic       udf;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of stored words plus the expected output beat.
  logic [7:0] mq[$];
  bit         m_valid;
  logic [7:0] m_data;
  bit         m_ovf;
  bit         m_udf;

  fifo_ram2_ctrl #(.DATA_W(8), .ADDR_W(8)) dut (
    .sclk    (sclk),
    .srst    (srst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .empty   (empty),
    .count   (count),
    .ovf     (ovf),
    .udf     (udf)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == 256));
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("udf", 32'(udf), 32'(m_udf));
    if (m_valid) chk("rd_data", 32'(rd_data), 32'(m_data));
  endtask

  // One clock: drive requests, advance the model by the FIFO rules, then compare.
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit rst);
    bit was_full;
    bit was_empty;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    srst    = rst;
    @(posedge sclk);
    was_full  = (mq.size() == 256);
    was_empty = (mq.size() == 0);
    if (rst) begin
      mq.delete();
      m_valid = 0;
      m_ovf   = 0;
      m_udf   = 0;
    end else begin
      m_valid = 0;
      if (w && was_full) m_ovf = 1;
      if (r && was_empty) m_udf = 1;
      if (r && !was_empty) begin
        m_data  = mq.pop_front();
        m_valid = 1;
      end
      if (w && !was_full) mq.push_back(d);
    end
    #1;
    check_model();
  endtask

  typedef struct {
    bit         w;
    logic [7:0] d;
    bit         r;
    int         exp_count;
    bit         exp_empty;
    bit         exp_valid;
    logic [7:0] exp_data;
    bit         exp_udf;
  } vec_t;

  vec_t vecs[11];

  initial begin
    wr_en   = 0;
    wr_data = 0;
    rd_en   = 0;
    srst    = 1;
    m_valid = 0;
    m_data  = 0;
    m_ovf   = 0;
    m_udf   = 0;

    // Push 1,2,3 then pop 3; underflow; push/pop on empty; push/pop with one entry.
    vecs[0]  = '{1, 8'h01, 0, 1, 0, 0, 8'h00, 0};
    vecs[1]  = '{1, 8'h02, 0, 2, 0, 0, 8'h00, 0};
    vecs[2]  = '{1, 8'h03, 0, 3, 0, 0, 8'h00, 0};
    vecs[3]  = '{0, 8'h00, 1, 2, 0, 1, 8'h01, 0};
    vecs[4]  = '{0, 8'h00, 1, 1, 0, 1, 8'h02, 0};
    vecs[5]  = '{0, 8'h00, 1, 0, 1, 1, 8'h03, 0};
    vecs[6]  = '{0, 8'h00, 0, 0, 1, 0, 8'h00, 0};
    vecs[7]  = '{0, 8'h00, 1, 0, 1, 0, 8'h00, 1};
    vecs[8]  = '{1, 8'hAA, 1, 1, 0, 0, 8'h00, 1};
    vecs[9]  = '{1, 8'hBB, 1, 1, 0, 1, 8'hAA, 1};
    vecs[10] = '{0, 8'h00, 1, 0, 1, 1, 8'hBB, 1};

    // Reset then idle.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("reset_count", 32'(count), 0);
    chk("reset_empty", 32'(empty), 1);
    chk("reset_full", 32'(full), 0);
    chk("reset_rd_valid", 32'(rd_valid), 0);
    chk("reset_ovf", 32'(ovf), 0);
    chk("reset_udf", 32'(udf), 0);

    foreach (vecs[i]) begin
      step(vecs[i].w, vecs[i].d, vecs[i].r, 0);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_udf", i), 32'(udf), 32'(vecs[i].exp_udf));
    end

    // Fill to 256, overflow once, drain in order.
    step(0, 0, 0, 1);
    for (int i = 0; i < 256; i++) step(1, 8'(i), 0, 0);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 256);
    step(1, 8'h5A, 0, 0);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_count", 32'(count), 256);
    for (int i = 0; i < 256; i++) begin
      step(0, 0, 1, 0);
      chk("drain_data", 32'(rd_data), 32'(i));
    end
    step(0, 0, 0, 0);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_ovf_sticky", 32'(ovf), 1);

    // Pop on empty.
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk("udf_set", 32'(udf), 1);
    chk("udf_no_valid", 32'(rd_valid), 0);
    chk("udf_count", 32'(count), 0);

    // 10 entries, simultaneous push/pop across pointer wrap.
    step(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 8'(i + 100), 0, 0);
    for (int i = 0; i < 300; i++) begin
      step(1, 8'(i * 7 + 3), 1, 0);
      chk("stream_count", 32'(count), 10);
    end

    // srst right after a pop with 5 entries stored.
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 8'(i + 1), 0, 0);
    step(0, 0, 1, 0);
    chk("pre_rst_valid", 32'(rd_valid), 1);
    chk("pre_rst_data", 32'(rd_data), 1);
    step(0, 0, 1, 1);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);

    // Randomized traffic with fill-biased and drain-biased phases.
    for (int i = 0; i < 3000; i++) begin
      int  phase;
      bit  w;
      bit  r;
      bit  rst;
      phase = (i / 400) % 3;
      case (phase)
        0:       begin w = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 2); end
        1:       begin w = ($urandom_range(0, 9) < 2); r = ($urandom_range(0, 9) < 8); end
        default: begin w = $urandom_range(0, 1) == 1;  r = $urandom_range(0, 1) == 1;  end
      endcase
      rst = ($urandom_range(0, 499) == 0);
      step(w, 8'($urandom), r, rst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
